// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// request-decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  function automatic logic is_legal_f3(input logic we, input logic [2:0] f3);
    logic legal;
    if (we) begin
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (f3 == F3_BU) || (f3 == F3_HU);
    end
    return legal;
  endfunction

  // Only meaningful for legal funct3 codes; callers gate with is_legal_f3.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store lane enables/replication and load
// extraction with sign or zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_mem_dataout,
  output logic [3:0]  o_byte_sel,
  output logic [31:0] o_mem_datain,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shifted;

  always_comb begin
    o_byte_sel   = 4'b0000;
    o_mem_datain = 32'h0;
    if (i_we) begin
      case (i_funct3)
        F3_B: begin
          o_byte_sel   = 4'b0001 << i_addr_lo;
          o_mem_datain = {4{i_wdata[7:0]}};
        end
        F3_H: begin
          o_byte_sel   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_mem_datain = {2{i_wdata[15:0]}};
        end
        F3_W: begin
          o_byte_sel   = 4'b1111;
          o_mem_datain = i_wdata;
        end
        default: begin
          o_byte_sel   = 4'b0000;
          o_mem_datain = 32'h0;
        end
      endcase
    end else begin
      // Loads fetch the whole word; lane selection happens on the way back.
      o_byte_sel = 4'b1111;
    end
  end

  assign w_shifted = i_mem_dataout >> {i_addr_lo, 3'b000};

  always_comb begin
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_load_data = i_mem_dataout;
      F3_BU:   o_load_data = {24'h0, w_shifted[7:0]};
      F3_HU:   o_load_data = {16'h0, w_shifted[15:0]};
      default: o_load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one byte-addressed request, performs a single
// word access on the data memory and returns an extended response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_misaligned,
  output logic        o_resp_fault,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_datain,
  output logic        o_mem_wen,
  output logic        o_mem_ren,
  output logic [3:0]  o_mem_byte_sel,
  input  logic [31:0] i_mem_dataout
);

  lsu_state_t  r_state, w_next_state;

  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_misaligned;
  logic        r_resp_fault;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_datain;
  logic        r_mem_wen;
  logic        r_mem_ren;
  logic [3:0]  r_mem_byte_sel;

  logic        w_accept;
  logic        w_capture;
  logic        w_legal;
  logic        w_misaligned;
  logic        w_range_fault;
  logic        w_fault;
  logic        w_error;
  logic [31:0] w_word_idx;
  logic [2:0]  w_align_f3;
  logic [1:0]  w_align_lo;
  logic [3:0]  w_byte_sel;
  logic [31:0] w_store_data;
  logic [31:0] w_load_data;

  assign w_word_idx    = {2'b00, i_req_addr[31:2]};
  assign w_legal       = is_legal_f3(i_req_we, i_req_funct3);
  assign w_misaligned  = w_legal && is_misaligned(i_req_funct3, i_req_addr[1:0]);
  assign w_range_fault = (w_word_idx >= 32'(MEM_WORDS));
  assign w_fault       = !w_legal || w_range_fault;
  assign w_error       = w_misaligned || w_fault;

  // The aligner sees the live request in IDLE (store steering) and the
  // registered request in ACCESS (load extraction).
  lsu_align u_align (
    .i_we          (i_req_we),
    .i_funct3      (w_align_f3),
    .i_addr_lo     (w_align_lo),
    .i_wdata       (i_req_wdata),
    .i_mem_dataout (i_mem_dataout),
    .o_byte_sel    (w_byte_sel),
    .o_mem_datain  (w_store_data),
    .o_load_data   (w_load_data)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next_state = w_error ? ST_RESP : ST_ACCESS;
      ST_ACCESS: w_next_state = ST_RESP;
      ST_RESP:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (r_state == ST_IDLE) && !i_reset;
    w_accept    = o_req_ready && i_req_valid;
    w_capture   = (r_state == ST_ACCESS);
    w_align_f3  = w_capture ? r_funct3  : i_req_funct3;
    w_align_lo  = w_capture ? r_addr_lo : i_req_addr[1:0];
  end

  // Response and enables default low each cycle so they pulse for one cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_we              <= 1'b0;
      r_funct3          <= 3'b000;
      r_addr_lo         <= 2'b00;
      r_resp_valid      <= 1'b0;
      r_resp_rdata      <= 32'h0;
      r_resp_misaligned <= 1'b0;
      r_resp_fault      <= 1'b0;
      r_mem_addr        <= 32'h0;
      r_mem_datain      <= 32'h0;
      r_mem_wen         <= 1'b0;
      r_mem_ren         <= 1'b0;
      r_mem_byte_sel    <= 4'b0000;
    end else begin
      r_resp_valid      <= 1'b0;
      r_resp_rdata      <= 32'h0;
      r_resp_misaligned <= 1'b0;
      r_resp_fault      <= 1'b0;
      r_mem_wen         <= 1'b0;
      r_mem_ren         <= 1'b0;
      if (w_accept) begin
        r_we           <= i_req_we;
        r_funct3       <= i_req_funct3;
        r_addr_lo      <= i_req_addr[1:0];
        r_mem_addr     <= w_word_idx;
        r_mem_datain   <= w_store_data;
        r_mem_byte_sel <= w_byte_sel;
        if (w_error) begin
          r_resp_valid      <= 1'b1;
          r_resp_misaligned <= w_misaligned;
          r_resp_fault      <= w_fault;
        end else begin
          r_mem_wen <= i_req_we;
          r_mem_ren <= !i_req_we;
        end
      end
      if (w_capture) begin
        r_resp_valid <= 1'b1;
        r_resp_rdata <= r_we ? 32'h0 : w_load_data;
      end
    end
  end

  assign o_resp_valid      = r_resp_valid;
  assign o_resp_rdata      = r_resp_rdata;
  assign o_resp_misaligned = r_resp_misaligned;
  assign o_resp_fault      = r_resp_fault;
  assign o_mem_addr        = r_mem_addr;
  assign o_mem_datain      = r_mem_datain;
  assign o_mem_wen         = r_mem_wen;
  assign o_mem_ren         = r_mem_ren;
  assign o_mem_byte_sel    = r_mem_byte_sel;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-level memory model plus
// per-cycle protocol checks and literal expectations from the test plan.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_datain;
  logic        mem_wen;
  logic        mem_ren;
  logic [3:0]  mem_byte_sel;
  logic [31:0] mem_dataout = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_req_valid       (req_valid),
    .o_req_ready       (req_ready),
    .i_req_we          (req_we),
    .i_req_funct3      (req_funct3),
    .i_req_addr        (req_addr),
    .i_req_wdata       (req_wdata),
    .o_resp_valid      (resp_valid),
    .o_resp_rdata      (resp_rdata),
    .o_resp_misaligned (resp_misaligned),
    .o_resp_fault      (resp_fault),
    .o_mem_addr        (mem_addr),
    .o_mem_datain      (mem_datain),
    .o_mem_wen         (mem_wen),
    .o_mem_ren         (mem_ren),
    .o_mem_byte_sel    (mem_byte_sel),
    .i_mem_dataout     (mem_dataout)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Data memory device: single-cycle access on the falling edge.
  logic [31:0] dev_mem [0:1023];
  logic [31:0] dev_word;
  always @(negedge clk) begin
    if (mem_ren) mem_dataout <= dev_mem[mem_addr[9:0]];
    if (mem_wen) begin
      dev_word = dev_mem[mem_addr[9:0]];
      for (int i = 0; i < 4; i++)
        if (mem_byte_sel[i]) dev_word[8*i +: 8] = mem_datain[8*i +: 8];
      dev_mem[mem_addr[9:0]] <= dev_word;
    end
  end

  // Reference model: byte-addressed memory image and the in-flight request.
  logic [7:0]  ref_bytes [0:4095];
  int          cyc = 0;
  int          m_acc = -10;
  int          m_resp = -10;
  int          m_size = 1;
  logic        m_we = 1'b0, m_err = 1'b0, m_mis = 1'b0, m_fault = 1'b0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_rdata = 32'h0, m_din = 32'h0;
  logic [3:0]  m_sel = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic model_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {3'b000, 3'b001, 3'b010};
    return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

  function automatic int model_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    int sz;
    v  = 32'h0;
    sz = model_size(f3);
    for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_bytes[int'(addr[11:0]) + k];
    if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // Per-cycle protocol compare against the model.
  always @(negedge clk) begin
    if (!reset) begin
      logic ex_ready, ex_rv, ex_wen, ex_ren;
      ex_ready = !(cyc >= m_acc && cyc <= m_resp);
      ex_rv    = (cyc == m_resp);
      ex_wen   = (cyc == m_acc) && !m_err && m_we;
      ex_ren   = (cyc == m_acc) && !m_err && !m_we;
      check("req_ready", {31'h0, req_ready}, {31'h0, ex_ready});
      check("resp_valid", {31'h0, resp_valid}, {31'h0, ex_rv});
      check("mem_wen", {31'h0, mem_wen}, {31'h0, ex_wen});
      check("mem_ren", {31'h0, mem_ren}, {31'h0, ex_ren});
      if (ex_wen || ex_ren) check("mem_addr", mem_addr, m_addr / 4);
      if (ex_wen) begin
        check("mem_byte_sel", {28'h0, mem_byte_sel}, {28'h0, m_sel});
        check("mem_datain", mem_datain, m_din);
      end
      if (ex_rv) begin
        check("resp_rdata", resp_rdata, m_rdata);
        check("resp_misaligned", {31'h0, resp_misaligned}, {31'h0, m_mis});
        check("resp_fault", {31'h0, resp_fault}, {31'h0, m_fault});
        if (m_we && !m_err)
          for (int k = 0; k < m_size; k++) ref_bytes[int'(m_addr[11:0]) + k] = m_wdata[8*k +: 8];
      end
    end
  end

  // Observations of the last transaction, pinned against literals by the main flow.
  logic [31:0] obs_addr, obs_din, obs_rdata;
  logic [3:0]  obs_sel;
  logic        obs_mis, obs_fault, obs_wen, obs_ren;
  int          obs_rv_cnt, obs_rv_off;

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    m_we    = we;
    m_addr  = addr;
    m_wdata = wdata;
    m_size  = model_size(f3);
    m_mis   = model_legal(we, f3) && ((addr % m_size) != 0);
    m_fault = !model_legal(we, f3) || ((addr / 4) >= 1024);
    m_err   = m_mis || m_fault;
    m_rdata = (we || m_err) ? 32'h0 : model_load(f3, addr);
    for (int i = 0; i < 4; i++) begin
      m_sel[i]       = (i >= (addr % 4)) && (i < (addr % 4) + m_size);
      m_din[8*i +: 8] = wdata[8*(i % m_size) +: 8];
    end
    m_acc  = cyc + 1;
    m_resp = m_err ? m_acc : m_acc + 1;
    obs_wen = 1'b0; obs_ren = 1'b0; obs_rv_cnt = 0; obs_rv_off = -1;
    obs_rdata = 32'hX; obs_mis = 1'bX; obs_fault = 1'bX;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (n == 0) begin
        req_valid = 1'b0;
        obs_addr  = mem_addr;
        obs_sel   = mem_byte_sel;
        obs_din   = mem_datain;
      end
      if (mem_wen) obs_wen = 1'b1;
      if (mem_ren) obs_ren = 1'b1;
      if (resp_valid) begin
        obs_rv_cnt++;
        obs_rv_off = n;
        obs_rdata  = resp_rdata;
        obs_mis    = resp_misaligned;
        obs_fault  = resp_fault;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) dev_mem[i] = 32'h0;
    for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'h0;

    #1;
    check("reset_ready_low", {31'h0, req_ready}, 32'h0);
    check("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("reset_mem_wen", {31'h0, mem_wen}, 32'h0);
    check("reset_mem_ren", {31'h0, mem_ren}, 32'h0);
    check("reset_rdata", resp_rdata, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    #22 reset = 1'b0;
    #1 check("ready_after_reset", {31'h0, req_ready}, 32'h1);

    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check("sw_mem_addr", obs_addr, 32'd4);
    check("sw_byte_sel", {28'h0, obs_sel}, 32'hF);
    check("sw_datain", obs_din, 32'hDEADBEEF);

    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_rdata", obs_rdata, 32'hDEADBEEF);
    check("lw_latency", obs_rv_off, 1);
    check("lw_one_pulse", obs_rv_cnt, 1);

    do_req(1'b1, 3'b000, 32'h13, 32'h000000A5);
    check("sb_byte_sel", {28'h0, obs_sel}, 32'h8);
    check("sb_datain", obs_din, 32'hA5A5A5A5);
    do_req(1'b0, 3'b000, 32'h13, 32'h0);
    check("lb_rdata", obs_rdata, 32'hFFFFFFA5);
    do_req(1'b0, 3'b100, 32'h13, 32'h0);
    check("lbu_rdata", obs_rdata, 32'h000000A5);

    do_req(1'b1, 3'b001, 32'h22, 32'h00008001);
    check("sh_byte_sel", {28'h0, obs_sel}, 32'hC);
    do_req(1'b0, 3'b001, 32'h22, 32'h0);
    check("lh_rdata", obs_rdata, 32'hFFFF8001);
    do_req(1'b0, 3'b101, 32'h22, 32'h0);
    check("lhu_rdata", obs_rdata, 32'h00008001);

    do_req(1'b0, 3'b010, 32'h06, 32'h0);
    check("lw_mis_flag", {31'h0, obs_mis}, 32'h1);
    check("lw_mis_latency", obs_rv_off, 0);
    check("lw_mis_no_ren", {31'h0, obs_ren}, 32'h0);
    do_req(1'b0, 3'b010, 32'h1000, 32'h0);
    check("lw_range_fault", {31'h0, obs_fault}, 32'h1);
    check("lw_range_not_mis", {31'h0, obs_mis}, 32'h0);

    do_req(1'b1, 3'b011, 32'h10, 32'h12345678);
    check("st011_fault", {31'h0, obs_fault}, 32'h1);
    check("st011_no_wen", {31'h0, obs_wen}, 32'h0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    check("word_unchanged", obs_rdata, 32'hA5ADBEEF);

    // Model-checked extras: other lanes, both error flags, illegal load codes.
    do_req(1'b0, 3'b000, 32'h11, 32'h0);
    check("lb_lane1", obs_rdata, 32'hFFFFFFBE);
    do_req(1'b0, 3'b101, 32'h10, 32'h0);
    do_req(1'b1, 3'b000, 32'h25, 32'h0000007E);
    do_req(1'b0, 3'b010, 32'h24, 32'h0);
    check("sb_lane1_word", obs_rdata, 32'h00007E00);
    do_req(1'b0, 3'b001, 32'h23, 32'h0);
    do_req(1'b1, 3'b001, 32'h21, 32'hFFFF);
    do_req(1'b0, 3'b010, 32'h1002, 32'h0);
    check("both_flags_mis", {31'h0, obs_mis}, 32'h1);
    check("both_flags_fault", {31'h0, obs_fault}, 32'h1);
    do_req(1'b0, 3'b011, 32'h10, 32'h0);
    do_req(1'b0, 3'b110, 32'h10, 32'h0);
    do_req(1'b1, 3'b001, 32'h20, 32'h0000C3C3);
    do_req(1'b0, 3'b010, 32'h20, 32'h0);

    // Reset during the ACCESS cycle of a store aborts it.
    do_req(1'b1, 3'b010, 32'h40, 32'h11223344);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h40;
    req_wdata  = 32'hCAFEF00D;
    @(posedge clk);
    #1 check("abort_wen_before", {31'h0, mem_wen}, 32'h1);
    #1 reset = 1'b1;
    #1;
    check("abort_wen_dropped", {31'h0, mem_wen}, 32'h0);
    check("abort_ready_low", {31'h0, req_ready}, 32'h0);
    check("abort_no_resp", {31'h0, resp_valid}, 32'h0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready_back", {31'h0, req_ready}, 32'h1);
    check("abort_no_resp_after", {31'h0, resp_valid}, 32'h0);
    do_req(1'b0, 3'b010, 32'h40, 32'h0);
    check("abort_word_kept", obs_rdata, 32'h11223344);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
